// File: rtl/bcd_countdown_pkg.sv
// bcd_countdown_pkg: shared types and helpers for the BCD mm:ss countdown.
//   state_t   - countdown FSM states
//   RES_*     - round outcome codes driven on the result port
//   wrap_lim  - value a digit takes when it underflows (9 for units, 5 for tens)
package bcd_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_DEFUSED = 2'd1;
    localparam logic [1:0] RES_TIMEOUT = 2'd2;
    localparam logic [1:0] RES_STRIKES = 2'd3;

    // Even-indexed digits are units (0..9), odd-indexed digits are tens (0..5).
    function automatic logic [3:0] wrap_lim(input int i);
        return (i % 2 == 1) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: one stage of the BCD borrow chain.
//   digit      - current BCD digit
//   borrow_in  - decrement request from the lower digits
//   lim        - value to wrap to on underflow
//   next_digit - digit after the (possible) decrement
//   borrow_out - this digit underflowed, so the next digit must decrement
//   zero       - digit is currently zero
module bcd_digit_dec
    import bcd_countdown_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    input  logic [3:0] lim,
    output logic [3:0] next_digit,
    output logic       borrow_out,
    output logic       zero
);

    assign zero       = (digit == 4'd0);
    assign borrow_out = zero & borrow_in;

    always_comb begin
        next_digit = digit;
        if (borrow_in) begin
            next_digit = zero ? lim : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// bcd_countdown: BCD mm:ss countdown with prescaler, strikes and round outcome.
//   Clk        - system clock (single domain)
//   reset      - asynchronous, active-low
//   start      - pulse; load START_VAL and begin a round (IDLE/DONE only)
//   pause      - level; freeze the count while high
//   strike     - pulse; record one strike (RUN/PAUSE only)
//   defuse     - pulse; end the round as defused (RUN/PAUSE only)
//   num        - current BCD digits, digit 0 = seconds units
//   tick       - one-cycle pulse in the cycle the digits change
//   dot        - colon blink: high for the first half of each period in RUN, else high
//   running    - high in RUN
//   strike_cnt - strikes recorded this round
//   result     - round outcome (RES_* codes)
module bcd_countdown
    import bcd_countdown_pkg::*;
#(
    parameter int                NDIG        = 4,
    parameter logic [4*NDIG-1:0] START_VAL   = 16'h0500,
    parameter int                TICK_DIV    = 1000,
    parameter int                MAX_STRIKES = 3
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              strike,
    input  logic              defuse,
    output logic [4*NDIG-1:0] num,
    output logic              tick,
    output logic              dot,
    output logic              running,
    output logic [2:0]        strike_cnt,
    output logic [1:0]        result
);

    localparam int PW = $clog2(TICK_DIV + 1);

    // Tick period for a given strike count: TICK_DIV halved per strike, floored at 1.
    function automatic logic [PW-1:0] period_of(input logic [2:0] s);
        logic [PW-1:0] p;
        p = PW'(TICK_DIV >> s);
        if (p == '0) begin
            p = PW'(1);
        end
        return p;
    endfunction

    state_t            state, state_n;
    logic [PW-1:0]     presc, presc_n, period;
    logic [4*NDIG-1:0] num_n, num_dec;
    logic [2:0]        strike_n;
    logic [1:0]        result_n;
    logic              tick_n, dot_n;

    logic [NDIG:0]     borrow;
    logic [NDIG-1:0]   zero;
    logic              at_zero, will_zero;

    // Borrow chain: digit 0 always receives the decrement request.
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < NDIG; i++) begin : g_dig
        bcd_digit_dec u_dig (
            .digit      (num[4*i +: 4]),
            .borrow_in  (borrow[i]),
            .lim        (wrap_lim(i)),
            .next_digit (num_dec[4*i +: 4]),
            .borrow_out (borrow[i+1]),
            .zero       (zero[i])
        );
    end

    // The chain only borrows out of the top digit when every digit is zero.
    assign at_zero   = borrow[NDIG];
    // Decrement lands on all-zeros exactly when the units digit goes 1 -> 0
    // and every higher digit is already zero.
    assign will_zero = !zero[0] && (num_dec[3:0] == 4'd0) && (&zero[NDIG-1:1]);

    assign period = period_of(strike_cnt);

    always_comb begin
        state_n  = state;
        presc_n  = presc;
        num_n    = num;
        strike_n = strike_cnt;
        result_n = result;
        tick_n   = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n  = RUN;
                    num_n    = START_VAL;
                    presc_n  = '0;
                    strike_n = '0;
                    result_n = RES_NONE;
                end
            end
            RUN, PAUSE: begin
                if (strike) begin
                    strike_n = strike_cnt + 3'd1;
                end
                if (defuse) begin
                    // Defuse outranks a coincident strike, which is dropped.
                    state_n  = DONE;
                    result_n = RES_DEFUSED;
                    strike_n = strike_cnt;
                end else if (strike && (strike_n == 3'(MAX_STRIKES))) begin
                    state_n  = DONE;
                    result_n = RES_STRIKES;
                end else if (state == RUN) begin
                    // >= rather than == so a shortened period wraps at once.
                    if (presc >= period - PW'(1)) begin
                        presc_n = '0;
                        if (at_zero) begin
                            state_n  = DONE;
                            result_n = RES_TIMEOUT;
                        end else begin
                            tick_n = 1'b1;
                            num_n  = num_dec;
                            if (will_zero) begin
                                state_n  = DONE;
                                result_n = RES_TIMEOUT;
                            end
                        end
                    end else if (pause) begin
                        state_n = PAUSE;
                    end else begin
                        presc_n = presc + PW'(1);
                    end
                end else if (!pause) begin
                    // Resume with the prescaler exactly where it was frozen.
                    state_n = RUN;
                end
            end
        endcase

        // dot is registered, so it is derived from the values about to be loaded.
        dot_n = 1'b1;
        if (state_n == RUN) begin
            dot_n = (presc_n < (period_of(strike_n) >> 1));
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            presc      <= '0;
            num        <= START_VAL;
            strike_cnt <= '0;
            result     <= RES_NONE;
            tick       <= 1'b0;
            dot        <= 1'b1;
            running    <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            num        <= num_n;
            strike_cnt <= strike_n;
            result     <= result_n;
            tick       <= tick_n;
            dot        <= dot_n;
            running    <= (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: directed bench for bcd_countdown.
//   u_a: TICK_DIV=4, START_VAL=0102 - countdown, pause, defuse, start-in-RUN, async reset
//   u_b: TICK_DIV=8, START_VAL=0500 - strike period shortening and strike-out
module tb_bcd_countdown;

    logic Clk   = 1'b0;
    logic reset = 1'b0;

    always #5 Clk = ~Clk;

    logic        a_start, a_pause, a_strike, a_defuse;
    logic [15:0] a_num;
    logic        a_tick, a_dot, a_running;
    logic [2:0]  a_strike_cnt;
    logic [1:0]  a_result;

    logic        b_start, b_pause, b_strike, b_defuse;
    logic [15:0] b_num;
    logic        b_tick, b_dot, b_running;
    logic [2:0]  b_strike_cnt;
    logic [1:0]  b_result;

    int n_checks = 0;
    int n_errors = 0;

    bcd_countdown #(.NDIG(4), .START_VAL(16'h0102), .TICK_DIV(4), .MAX_STRIKES(3)) u_a (
        .Clk(Clk), .reset(reset), .start(a_start), .pause(a_pause), .strike(a_strike),
        .defuse(a_defuse), .num(a_num), .tick(a_tick), .dot(a_dot), .running(a_running),
        .strike_cnt(a_strike_cnt), .result(a_result)
    );

    bcd_countdown #(.NDIG(4), .START_VAL(16'h0500), .TICK_DIV(8), .MAX_STRIKES(3)) u_b (
        .Clk(Clk), .reset(reset), .start(b_start), .pause(b_pause), .strike(b_strike),
        .defuse(b_defuse), .num(b_num), .tick(b_tick), .dot(b_dot), .running(b_running),
        .strike_cnt(b_strike_cnt), .result(b_result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Reference mm:ss BCD encoding of a seconds count.
    function automatic logic [15:0] mmss(input int secs);
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    initial begin
        a_start = 0; a_pause = 0; a_strike = 0; a_defuse = 0;
        b_start = 0; b_pause = 0; b_strike = 0; b_defuse = 0;

        // Reset values
        #12;
        check("rst_num",     32'(a_num), 'h0102);
        check("rst_tick",    32'(a_tick), 0);
        check("rst_dot",     32'(a_dot), 1);
        check("rst_running", 32'(a_running), 0);
        check("rst_strikes", 32'(a_strike_cnt), 0);
        check("rst_result",  32'(a_result), 0);
        check("rst_b_num",   32'(b_num), 'h0500);
        reset = 1;
        step(1);

        // Strike in IDLE is ignored
        b_strike = 1; step(1); b_strike = 0;
        check("idle_strike", 32'(b_strike_cnt), 0);

        // Strike at prescaler 2->3 with TICK_DIV=8: P drops to 4, tick next edge
        b_start = 1; step(1); b_start = 0;
        check("b_running", 32'(b_running), 1);
        check("b_num0", 32'(b_num), 'h0500);
        step(2);
        b_strike = 1; step(1); b_strike = 0;
        check("b_strike1_cnt", 32'(b_strike_cnt), 1);
        check("b_strike1_tick", 32'(b_tick), 0);
        check("b_strike1_dot", 32'(b_dot), 0);
        step(1);
        check("b_early_tick", 32'(b_tick), 1);
        check("b_early_num", 32'(b_num), 'h0459);
        step(3);
        check("b_p4_notick", 32'(b_tick), 0);
        step(1);
        check("b_p4_tick", 32'(b_tick), 1);
        check("b_p4_num", 32'(b_num), 'h0458);

        // Second strike (P=2), third strike lands on a tick edge
        b_strike = 1; step(1); b_strike = 0;
        check("b_strike2_cnt", 32'(b_strike_cnt), 2);
        check("b_strike2_tick", 32'(b_tick), 0);
        b_strike = 1; step(1); b_strike = 0;
        check("b_out_result", 32'(b_result), 3);
        check("b_out_cnt", 32'(b_strike_cnt), 3);
        check("b_out_num", 32'(b_num), 'h0458);
        check("b_out_tick", 32'(b_tick), 0);
        check("b_out_running", 32'(b_running), 0);
        check("b_out_dot", 32'(b_dot), 1);
        b_strike = 1; step(1); b_strike = 0;
        check("done_strike", 32'(b_strike_cnt), 3);

        // Full countdown 0102 -> 0000 with P=4
        a_start = 1; step(1); a_start = 0;
        check("a_running", 32'(a_running), 1);
        check("a_num0", 32'(a_num), 'h0102);
        check("a_dot0", 32'(a_dot), 1);
        for (int k = 1; k <= 62; k++) begin
            for (int j = 0; j < 3; j++) begin
                step(1);
                if (k == 1) check("a_dot_phase", 32'(a_dot), (j == 0) ? 1 : 0);
                if (j == 2) check("a_pre_tick", 32'(a_tick), 0);
            end
            step(1);
            check("a_tick", 32'(a_tick), 1);
            check("a_num", 32'(a_num), 32'(mmss(62 - k)));
            check("a_run_flag", 32'(a_running), (k < 62) ? 1 : 0);
        end
        check("timeout_result", 32'(a_result), 2);
        check("timeout_dot", 32'(a_dot), 1);
        step(2);
        check("timeout_hold_num", 32'(a_num), 0);
        check("timeout_hold_tick", 32'(a_tick), 0);
        check("timeout_hold_res", 32'(a_result), 2);

        // Pause for 20 edges mid-period, then resume from the held prescaler
        a_start = 1; step(1); a_start = 0;
        check("restart_result", 32'(a_result), 0);
        step(4);
        check("p_tick", 32'(a_tick), 1);
        check("p_num", 32'(a_num), 'h0101);
        step(1);
        a_pause = 1; step(1);
        check("pause_running", 32'(a_running), 0);
        check("pause_dot", 32'(a_dot), 1);
        step(19);
        check("pause_num", 32'(a_num), 'h0101);
        check("pause_tick", 32'(a_tick), 0);
        check("pause_dot_held", 32'(a_dot), 1);
        a_pause = 0; step(1);
        check("resume_running", 32'(a_running), 1);
        check("resume_dot1", 32'(a_dot), 1);
        step(1);
        check("resume_dot2", 32'(a_dot), 0);
        step(1);
        check("resume_notick", 32'(a_tick), 0);
        step(1);
        check("resume_tick", 32'(a_tick), 1);
        check("resume_num", 32'(a_num), 'h0100);

        // Non-final strike, then defuse + strike together on a would-be tick edge
        a_strike = 1; step(1); a_strike = 0;
        check("a_strike_cnt", 32'(a_strike_cnt), 1);
        a_defuse = 1; a_strike = 1; step(1); a_defuse = 0; a_strike = 0;
        check("defuse_result", 32'(a_result), 1);
        check("defuse_cnt", 32'(a_strike_cnt), 1);
        check("defuse_running", 32'(a_running), 0);
        check("defuse_num", 32'(a_num), 'h0100);
        check("defuse_tick", 32'(a_tick), 0);
        step(3);
        check("defuse_hold", 32'(a_num), 'h0100);
        a_start = 1; step(1); a_start = 0;
        check("rs_num", 32'(a_num), 'h0102);
        check("rs_cnt", 32'(a_strike_cnt), 0);
        check("rs_result", 32'(a_result), 0);
        check("rs_running", 32'(a_running), 1);

        // start in RUN is ignored, then async reset between edges
        step(6);
        check("ign_pre_num", 32'(a_num), 'h0101);
        a_start = 1; step(1); a_start = 0;
        check("ign_num", 32'(a_num), 'h0101);
        check("ign_running", 32'(a_running), 1);
        step(1);
        check("ign_tick", 32'(a_tick), 1);
        check("ign_tick_num", 32'(a_num), 'h0100);
        #2 reset = 0;
        #1;
        check("arst_num", 32'(a_num), 'h0102);
        check("arst_tick", 32'(a_tick), 0);
        check("arst_running", 32'(a_running), 0);
        check("arst_dot", 32'(a_dot), 1);
        check("arst_result", 32'(a_result), 0);
        check("arst_b_cnt", 32'(b_strike_cnt), 0);
        #2 reset = 1;
        step(2);
        check("post_rst_idle", 32'(a_running), 0);
        check("post_rst_num", 32'(a_num), 'h0102);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
# bcd_countdown

Parametrised, fully synchronous BCD mm:ss countdown for the bomb module. It counts down a configurable number of digit pairs from a preset value using an internal prescaler. Strikes shorten the tick period, and the block reports the outcome of each round as defused, timed out, or failed on strikes. The BCD digits and the colon-blink bit feed the 7-segment display multiplexer.

## Interface
Parameters:
- NDIG, 4: number of BCD digits; must be even and ≥2. Digit 0 is seconds units; odd-indexed digits are tens (modulo 6).
- START_VAL, 16'h0500: preset value, 4*NDIG bits, one BCD nibble per digit. Odd-indexed nibbles must be ≤5 and even-indexed nibbles ≤9.
- TICK_DIV, 1000: Clk cycles per count at zero strikes; must be ≥2.
- MAX_STRIKES, 3: strike count that ends the round; range 1..7.

Ports:
- Clk, input, 1: system clock. The whole block uses this single domain with no derived clocks.
- reset, input, 1: asynchronous, active-low.
- start, input, 1: one-cycle pulse. Loads START_VAL, clears strikes, and begins the count. Accepted only in IDLE or DONE.
- pause, input, 1: level; freezes the count while high.
- strike, input, 1: one-cycle pulse; records one strike.
- defuse, input, 1: one-cycle pulse; ends the round as defused.
- num, output, 4*NDIG: current BCD digits.
- tick, output, 1: one-cycle pulse, asserted in the cycle the digits change.
- dot, output, 1: colon-blink bit.
- running, output, 1: high in RUN only.
- strike_cnt, output, 3: strikes recorded this round.
- result, output, 2: 0 = none, 1 = defused, 2 = timed out, 3 = failed on strikes.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values: IDLE, num=START_VAL, prescaler=0, strike_cnt=0, result=0, tick=0, running=0, dot=1.
- IDLE: start moves to RUN with num reloaded and prescaler=0.
- RUN:
  - Prescaler counts 0..P-1, where P = max(TICK_DIV >> strike_cnt, 1).
  - At P-1 the prescaler returns to 0, tick pulses, and num decrements by one second.
- Decrement rule:
  - Digit i decrements only if all lower digits are zero (borrow chain).
  - An underflowing digit wraps to 9 for even i and to 5 for odd i.
  - There is no decrement past all-zeros.
- The tick that produces all-zeros moves to DONE with result=2; num holds at zero.
- pause high in RUN moves to PAUSE, with the prescaler and num frozen. pause low in PAUSE returns to RUN, and the prescaler resumes from its held value.
- strike in RUN or PAUSE increments strike_cnt. If the new value equals MAX_STRIKES, the block goes to DONE with result=3. Strikes in IDLE or DONE are ignored.
- Period change after a strike:
  - P is recomputed from strike_cnt every cycle.
  - If the prescaler is ≥ new P-1, the wrap and tick occur on the next RUN cycle.
- defuse in RUN or PAUSE goes to DONE with result=1; num freezes.
- DONE: outputs hold. start reloads num, clears strike_cnt and result, and enters RUN.
- start in RUN or PAUSE is ignored.
- Simultaneous events, highest priority first:
  1. reset
  2. defuse
  3. strike reaching MAX_STRIKES
  4. tick reaching zero
  5. ordinary tick
  6. pause
- On a non-final strike coinciding with a tick, both take effect in that cycle.
- dot: in RUN, dot = (prescaler < P/2). In every other state dot=1.

## Timing
- All outputs are registered. Every input acts on the first Clk edge at which it is sampled.
- start to running=1: 1 cycle. The first tick comes P cycles after running rises.
- The state change, the num update, and the result update land on the same edge; tick and result are visible in the same cycle.
- An asynchronous reset assertion mid-round forces the reset values immediately. Release is synchronised by the surrounding design.

## Structure
- bcd_countdown_pkg holds:
  - the state enum
  - the result codes (RES_NONE, RES_DEFUSED, RES_TIMEOUT, RES_STRIKES)
  - the function wrap_lim(i), returning 9 or 5
- Sub-module bcd_digit_dec, one instance per digit:
  - inputs: digit, borrow_in, wrap limit
  - outputs: next digit, borrow_out (digit==0 & borrow_in), zero
- The top level holds the FSM, prescaler, strike counter and dot.

## Test plan
- TICK_DIV=4, START_VAL=16'h0102, start: tick every 4 cycles; num goes 0102, 0101, 0100, 0059, 0058, …, 0000, then result=2 and running=0.
- TICK_DIV=8, one strike at t=3: P becomes 4; prescaler 3 ≥ 3, so the tick fires next cycle, then every 4 cycles; strike_cnt=1.
- MAX_STRIKES=3, three strike pulses, the third coinciding with a tick: result=3, num not decremented on that edge.
- pause held 20 cycles mid-count: num, prescaler and dot frozen with dot=1; the count resumes at the held prescaler value.
- defuse and strike in the same cycle: result=1 and strike_cnt unchanged. Then start: num=START_VAL, strike_cnt=0, result=0, running=1.
- reset asserted mid-RUN between edges: all outputs return to their reset values before the next Clk edge; start in RUN is ignored.
